// File: rtl/de10lite_sopc_pio_key_in_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO: register access plus level irq.
interface de10lite_sopc_pio_key_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/de10lite_sopc_pio_key_in.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C), maskable level irq.
// Optional per-bit debounce filter enabled by defining PIO_KEY_DEBOUNCE_EN.
module de10lite_sopc_pio_key_in #(
  parameter int               WIDTH        = 4,
  parameter int               EDGE_TYPE    = 1,
  parameter logic [WIDTH-1:0] RESET_MASK   = '0,
  parameter int               DEBOUNCE_CYC = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  de10lite_sopc_pio_key_in_if.slave bus,
  input  logic [WIDTH-1:0]       in_port
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_ec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int             CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0]    r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_filt;

  // A bit is accepted only after sync2 has disagreed with filt for DEBOUNCE_CYC cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= '0;
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == TC) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= '0;
    else          r_prev <= w_filt;
  end

  always_comb begin
    w_rise = w_filt & ~r_prev;
    w_fall = ~w_filt & r_prev;
    case (EDGE_TYPE)
      0:       w_edge = w_rise;
      1:       w_edge = w_fall;
      default: w_edge = w_rise | w_fall;
    endcase
  end

  assign w_wdata   = bus.writedata[WIDTH-1:0];
  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_wr_mask = w_wr && (bus.address == 2'd2);
  assign w_wr_ec   = w_wr && (bus.address == 2'd3);

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic w_unused_wdata;
      assign w_unused_wdata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mask <= RESET_MASK;
    else if (w_wr_mask) r_mask <= w_wdata;
  end

  // New edges are OR-ed in after the clear, so a same-cycle set beats the W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
    end else if (w_wr_ec) begin
      r_edge_cap <= (r_edge_cap & ~w_wdata) | w_edge;
    end else begin
      r_edge_cap <= r_edge_cap | w_edge;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= |(r_edge_cap & r_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    r_readdata <= 32'(w_filt);
        2'd2:    r_readdata <= 32'(r_mask);
        2'd3:    r_readdata <= 32'(r_edge_cap);
        default: r_readdata <= '0;
      endcase
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;

endmodule

// File: tb/tb_de10lite_sopc_pio_key_in.sv
// Directed self-checking bench for the key input PIO (WIDTH=4, falling-edge capture).
module tb_de10lite_sopc_pio_key_in;

`ifdef PIO_KEY_DEBOUNCE_EN
  localparam int DB = 8;
  localparam int XL = 8;
`else
  localparam int DB = 50000;
  localparam int XL = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] in_port;
  int         n_tests;
  int         n_fail;
  logic [31:0] rd;

  de10lite_sopc_pio_key_in_if bus_if ();

  de10lite_sopc_pio_key_in #(
    .WIDTH       (4),
    .EDGE_TYPE   (1),
    .RESET_MASK  (4'h0),
    .DEBOUNCE_CYC(DB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave),
    .in_port(in_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick(1);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    tick(1);
    d = bus_if.readdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_if.address = 2'd0;
    tick(3);
    n_tests++;
    if (bus_if.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h expected %h", bus_if.readdata, 32'h0);
    end
    n_tests++;
    if (bus_if.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b expected 0", bus_if.irq);
    end
    reset_n = 1'b1;
    tick(2 + XL);
    n_tests++;
    if (bus_if.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data_early: got %h expected %h", bus_if.readdata, 32'h0);
    end
    tick(1);
    n_tests++;
    if (bus_if.readdata !== 32'hF) begin
      n_fail++; $display("FAIL reset_data_3edges: got %h expected %h", bus_if.readdata, 32'hF);
    end
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reset_edgecap: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_falling_edge();
    bus_write(2'd2, 32'h4);
    bus_if.address = 2'd3;
    in_port = 4'hB;
    tick(3 + XL);
    n_tests++;
    if (bus_if.irq !== 1'b0 || bus_if.readdata !== 32'h0) begin
      n_fail++; $display("FAIL fall_edge3: got irq=%b cap=%h expected irq=0 cap=0", bus_if.irq, bus_if.readdata);
    end
    tick(1);
    n_tests++;
    if (bus_if.readdata !== 32'h4) begin
      n_fail++; $display("FAIL fall_capture: got %h expected %h", bus_if.readdata, 32'h4);
    end
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL fall_irq_edge4: got %b expected 1", bus_if.irq);
    end
    bus_write(2'd3, 32'h4);
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL fall_irq_clear_edge: got %b expected 1", bus_if.irq);
    end
    tick(1);
    n_tests++;
    if (bus_if.irq !== 1'b0) begin
      n_fail++; $display("FAIL fall_irq_after_clear: got %b expected 0", bus_if.irq);
    end
    in_port = 4'hF;
    tick(6 + XL);
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL rise_ignored: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_masked_bit();
    bus_write(2'd2, 32'h0);
    in_port = 4'hE;
    tick(2 + XL);
    in_port = 4'hF;
    tick(6 + XL);
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL masked_capture: got %h expected %h", rd, 32'h1);
    end
    n_tests++;
    if (bus_if.irq !== 1'b0) begin
      n_fail++; $display("FAIL masked_irq: got %b expected 0", bus_if.irq);
    end
    bus_write(2'd2, 32'h1);
    n_tests++;
    if (bus_if.irq !== 1'b0) begin
      n_fail++; $display("FAIL unmask_irq_same_edge: got %b expected 0", bus_if.irq);
    end
    tick(1);
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL unmask_irq: got %b expected 1", bus_if.irq);
    end
    bus_write(2'd3, 32'h1);
    bus_write(2'd2, 32'h0);
    tick(2);
  endtask

  task automatic test_collision();
    bus_write(2'd2, 32'h2);
    in_port = 4'hD;
    tick(2 + XL);
    bus_write(2'd3, 32'h2);
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h2) begin
      n_fail++; $display("FAIL collision_cap: got %h expected %h", rd, 32'h2);
    end
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL collision_irq: got %b expected 1", bus_if.irq);
    end
    tick(1);
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL collision_irq_hold: got %b expected 1", bus_if.irq);
    end
    in_port = 4'hF;
    tick(4 + XL);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
    tick(2);
  endtask

`ifdef PIO_KEY_DEBOUNCE_EN
  task automatic test_debounce();
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    tick(20);
    bus_read(2'd0, rd);
    n_tests++;
    if (rd !== 32'hF) begin
      n_fail++; $display("FAIL db_glitch_data: got %h expected %h", rd, 32'hF);
    end
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL db_glitch_cap: got %h expected %h", rd, 32'h0);
    end
    in_port = 4'hE;
    tick(12);
    tick(4);
    bus_read(2'd0, rd);
    n_tests++;
    if (rd !== 32'hE) begin
      n_fail++; $display("FAIL db_accept_data: got %h expected %h", rd, 32'hE);
    end
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL db_accept_cap: got %h expected %h", rd, 32'h1);
    end
    in_port = 4'hF;
    tick(20);
    bus_write(2'd3, 32'hF);
  endtask
`endif

  task automatic test_regs_and_reset();
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL reserved_read: got %h expected %h", rd, 32'h0);
    end
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2, rd);
    n_tests++;
    if (rd !== 32'hF) begin
      n_fail++; $display("FAIL mask_upper_bits: got %h expected %h", rd, 32'hF);
    end
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, rd);
    n_tests++;
    if (rd !== 32'hF) begin
      n_fail++; $display("FAIL data_write_ignored: got %h expected %h", rd, 32'hF);
    end
    in_port = 4'h7;
    tick(3 + XL);
    tick(1);
    n_tests++;
    if (bus_if.irq !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", bus_if.irq);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus_if.irq !== 1'b0 || bus_if.readdata !== 32'h0) begin
      n_fail++; $display("FAIL midreset_clear: got irq=%b rd=%h expected irq=0 rd=0", bus_if.irq, bus_if.readdata);
    end
    tick(2);
    reset_n = 1'b1;
    tick(4 + XL);
    bus_read(2'd3, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL release_no_edge: got %h expected %h", rd, 32'h0);
    end
    bus_read(2'd2, rd);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL release_mask: got %h expected %h", rd, 32'h0);
    end
    bus_read(2'd0, rd);
    n_tests++;
    if (rd !== 32'h7) begin
      n_fail++; $display("FAIL release_data: got %h expected %h", rd, 32'h7);
    end
    n_tests++;
    if (bus_if.irq !== 1'b0) begin
      n_fail++; $display("FAIL release_irq: got %b expected 0", bus_if.irq);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    test_reset();
    test_falling_edge();
    test_masked_bit();
    test_collision();
`ifdef PIO_KEY_DEBOUNCE_EN
    test_debounce();
`endif
    test_regs_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
